// File: rtl/gf180mcu_osu_sc_clk_pkg.sv
// Shared definitions for the 12T 3.3V programmable clock-divider cells.
//   RATIO_MIN   : smallest legal divide ratio; smaller requests are clamped up
//   cd_state_e  : divider run state (idle / period in progress)
//   clamp_ratio : maps a requested ratio onto the legal range
package gf180mcu_osu_sc_clk_pkg;

  localparam int RATIO_MIN = 2;

  typedef enum logic {
    CD_IDLE = 1'b0,
    CD_RUN  = 1'b1
  } cd_state_e;

  // Ratios 0 and 1 cannot produce both an active and an idle phase,
  // so they are raised to the minimum.
  function automatic logic [31:0] clamp_ratio(input logic [31:0] d);
    return (d < 32'(RATIO_MIN)) ? 32'(RATIO_MIN) : d;
  endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_gp12t3v3__clkdiv_cnt.sv
// Wrapping modulo-R period counter for the programmable clock divider.
//   clk, rst : source clock, async active-high reset
//   ratio    : current period length R (>= 2)
//   clr      : synchronous clear to 0 (wins over hold)
//   hold     : freeze the count
//   cnt      : registered count, 0..R-1
//   cnt_nxt  : value cnt takes at the next edge (lets the parent register
//              outputs that line up with the count)
//   tc       : cnt is at R-1 (combinational, qualified by the parent)
module gf180mcu_osu_sc_gp12t3v3__clkdiv_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ratio,
  input  logic             clr,
  input  logic             hold,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] cnt_nxt,
  output logic             tc
);

  logic [WIDTH-1:0] last;

  assign last = ratio - WIDTH'(1);
  assign tc   = (cnt == last);

  always_comb begin
    cnt_nxt = cnt;
    if (clr)        cnt_nxt = '0;
    else if (!hold) cnt_nxt = tc ? '0 : cnt + WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

endmodule

// File: rtl/gf180mcu_osu_sc_gp12t3v3__clkdiv_prog.sv
// Programmable glitch-free clock divider (12T 3.3V clock-cell family).
// Divide-by-R output: Y is active (~INV) for the first R>>1 cycles of each
// period and idle (INV) for the remaining ceil(R/2). Ratio changes go through
// a pending register and only take effect at a period boundary or at start;
// a stop request finishes the current period before idling.
//   CLK  : source clock          RST  : async active-high reset
//   EN   : run request           DIV  : requested ratio, captured on LOAD
//   LOAD : capture strobe        Y/YN : divided clock and its complement
//   TC   : last cycle of period  PEND : captured ratio not yet applied
//   RUN  : period in progress
// All outputs are flop outputs. RST is expected to be released synchronously
// to CLK by the surrounding reset logic.
module gf180mcu_osu_sc_gp12t3v3__clkdiv_prog
  import gf180mcu_osu_sc_clk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter bit INV   = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  input  logic             LOAD,
  output logic             Y,
  output logic             YN,
  output logic             TC,
  output logic             PEND,
  output logic             RUN
);

  localparam logic [WIDTH-1:0] RMIN = WIDTH'(RATIO_MIN);

  cd_state_e        state_q, state_nxt;
  logic [WIDTH-1:0] ratio_q, ratio_nxt;
  logic [WIDTH-1:0] pend_ratio_q, pend_ratio_nxt;
  logic             pend_q, pend_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic             cnt_tc, boundary, start, stop, apply;
  logic             run_nxt, act_nxt, tc_nxt;
  logic             y_q, yn_q, tc_q;

  // Period counter; compares against the ratio of the period in progress.
  gf180mcu_osu_sc_gp12t3v3__clkdiv_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk     (CLK),
    .rst     (RST),
    .ratio   (ratio_q),
    .clr     (start | stop),
    .hold    ((state_q == CD_IDLE) & ~start),
    .cnt     (cnt),
    .cnt_nxt (cnt_nxt),
    .tc      (cnt_tc)
  );

  assign boundary = (state_q == CD_RUN) & cnt_tc;

  // FSM: EN is looked at continuously while idle, but only at a boundary
  // while running, so a period is never truncated.
  always_comb begin
    state_nxt = state_q;
    start     = 1'b0;
    stop      = 1'b0;
    case (state_q)
      CD_IDLE: if (EN) begin
        state_nxt = CD_RUN;
        start     = 1'b1;
      end
      CD_RUN: if (boundary && !EN) begin
        state_nxt = CD_IDLE;
        stop      = 1'b1;
      end
      default: state_nxt = CD_IDLE;
    endcase
  end

  // Ratio reload. A LOAD on the applying edge refills the pending register,
  // so that value waits for the next boundary while the older one goes live.
  always_comb begin
    apply          = pend_q & (boundary | start);
    ratio_nxt      = apply ? pend_ratio_q : ratio_q;
    pend_ratio_nxt = LOAD ? WIDTH'(clamp_ratio(32'(DIV))) : pend_ratio_q;
    pend_nxt       = LOAD | (pend_q & ~apply);
  end

  // Outputs are decoded from the next count/ratio and registered, so they
  // describe the cycle the counter is about to enter.
  always_comb begin
    run_nxt = (state_nxt == CD_RUN);
    act_nxt = run_nxt & (cnt_nxt < (ratio_nxt >> 1));
    tc_nxt  = run_nxt & (cnt_nxt == (ratio_nxt - WIDTH'(1)));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= CD_IDLE;
      ratio_q      <= RMIN;
      pend_ratio_q <= RMIN;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      ratio_q      <= ratio_nxt;
      pend_ratio_q <= pend_ratio_nxt;
      pend_q       <= pend_nxt;
    end
  end

  // Y and YN are separate flops so neither is an inverter of the other.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      y_q  <= INV;
      yn_q <= ~INV;
      tc_q <= 1'b0;
    end else begin
      y_q  <= act_nxt ^ INV;
      yn_q <= ~(act_nxt ^ INV);
      tc_q <= tc_nxt;
    end
  end

  assign Y    = y_q;
  assign YN   = yn_q;
  assign TC   = tc_q;
  assign PEND = pend_q;
  assign RUN  = (state_q == CD_RUN);

  specify
    (CLK => Y)  = 0;
    (CLK => YN) = 0;
    (CLK => TC) = 0;
    (RST => Y)  = 0;
  endspecify

endmodule
